// File: rtl/cam_byte_sync.sv
// cam_byte_sync: front-end for an OV7670-style camera running YUV422.
// Registers the raw camera bus, tracks frames and lines with a small FSM,
// and selects the luma byte of each byte pair for the line-capture stage.
//
// Ports
//   pclk         camera pixel clock, all logic on its rising edge
//   reset        asynchronous, active-low
//   cam_vsync    raw vsync, active-high pulse between frames
//   cam_href     raw href, high for 2*COLS byte cycles of a line
//   cam_data     raw camera byte
//   enable       capture enable
//   luma_phase   0: Y is first byte of each pair (YUYV), 1: second (UYVY)
//   vsync_out    registered vsync, forced low while idle
//   href_out     registered href, forced low while idle
//   pix_data     luma byte, valid when pix_valid=1 (holds otherwise)
//   pix_valid    one-cycle strobe per delivered pixel
//   frame_count  frames delivered since reset, wraps
//   line_err     one-cycle pulse on a malformed or aborted line
//   frame_err    one-cycle pulse when a frame's line count != ROWS
module cam_byte_sync #(
  parameter int COLS        = 320,
  parameter int ROWS        = 240,
  parameter int SKIP_FRAMES = 2,
  parameter int FCNT_W      = 16
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  input  logic              enable,
  input  logic              luma_phase,
  output logic              vsync_out,
  output logic              href_out,
  output logic [7:0]        pix_data,
  output logic              pix_valid,
  output logic [FCNT_W-1:0] frame_count,
  output logic              line_err,
  output logic              frame_err
);

  localparam logic [10:0] LINE_LEN = 11'(2 * COLS);
  localparam logic [8:0]  ROWS_L   = 9'(ROWS);
  localparam logic [9:0]  ROWS_W   = 10'(ROWS);
  localparam logic [7:0]  SKIP_L   = 8'(SKIP_FRAMES);

  typedef enum logic [1:0] {IDLE, SYNC, SKIP, FRAME} state_t;

  state_t              state_q, state_d;
  logic                s1_vsync_q, s1_vsync_d;
  logic                s1_href_q, s1_href_d;
  logic [7:0]          s1_data_q, s1_data_d;
  logic                vs_prev_q, vs_prev_d;
  logic                hr_prev_q, hr_prev_d;
  logic                byte_phase_q, byte_phase_d;
  logic                line_abort_q, line_abort_d;
  logic [10:0]         line_bytes_q, line_bytes_d;
  logic [8:0]          line_cnt_q, line_cnt_d;
  logic [7:0]          skip_cnt_q, skip_cnt_d;
  logic                vsync_out_q, vsync_out_d;
  logic                href_out_q, href_out_d;
  logic [7:0]          pix_data_q, pix_data_d;
  logic                pix_valid_q, pix_valid_d;
  logic [FCNT_W-1:0]   frame_count_q, frame_count_d;
  logic                line_err_q, line_err_d;
  logic                frame_err_q, frame_err_d;

  logic                vs_rise, href_fall, line_ok, pix_ok;
  logic [9:0]          lines_total;

  always_comb begin
    state_d       = state_q;
    skip_cnt_d    = skip_cnt_q;
    frame_count_d = frame_count_q;
    frame_err_d   = 1'b0;

    s1_vsync_d = cam_vsync;
    s1_href_d  = cam_href;
    s1_data_d  = cam_data;
    vs_prev_d  = s1_vsync_q;
    hr_prev_d  = s1_href_q;

    vs_rise   = s1_vsync_q & ~vs_prev_q;
    href_fall = hr_prev_q & ~s1_href_q;
    // A line that ends inside FRAME and was not cut by a vsync rise.
    line_ok   = href_fall & (state_q == FRAME) & ~line_abort_q;

    byte_phase_d = s1_href_q ? ~byte_phase_q : 1'b0;
    if (!s1_href_q)
      line_bytes_d = '0;
    else if (line_bytes_q == '1)
      line_bytes_d = line_bytes_q;
    else
      line_bytes_d = line_bytes_q + 11'd1;

    // Once vsync rises mid-line, the rest of that line is dead until href drops.
    line_abort_d = s1_href_q & (line_abort_q | vs_rise);

    // Frame check includes a line that ends on the same cycle vsync rises.
    lines_total = {1'b0, line_cnt_q} + {9'd0, line_ok};
    if (vs_rise)
      line_cnt_d = '0;
    else if (line_ok && line_cnt_q != '1)
      line_cnt_d = line_cnt_q + 9'd1;
    else
      line_cnt_d = line_cnt_q;

    pix_ok = (state_q == FRAME) & s1_href_q & ~line_abort_q &
             (byte_phase_q == luma_phase) & (line_bytes_q < LINE_LEN) &
             (line_cnt_q < ROWS_L);
    pix_valid_d = pix_ok;
    pix_data_d  = pix_ok ? s1_data_q : pix_data_q;

    vsync_out_d = (state_q != IDLE) & s1_vsync_q;
    href_out_d  = (state_q != IDLE) & s1_href_q;

    line_err_d = (line_ok & (line_cnt_q < ROWS_L) & (line_bytes_q != LINE_LEN)) |
                 (vs_rise & s1_href_q & (state_q != IDLE));

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d    = SYNC;
          skip_cnt_d = SKIP_L;
        end
      end
      SYNC: begin
        if (vs_rise) state_d = (skip_cnt_q != '0) ? SKIP : FRAME;
      end
      SKIP: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (vs_rise) begin
          skip_cnt_d = skip_cnt_q - 8'd1;
          if (skip_cnt_q <= 8'd1) state_d = FRAME;
        end
      end
      FRAME: begin
        if (vs_rise) begin
          frame_count_d = frame_count_q + FCNT_W'(1);
          frame_err_d   = (lines_total != ROWS_W);
          state_d       = enable ? FRAME : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      s1_vsync_q    <= 1'b0;
      s1_href_q     <= 1'b0;
      s1_data_q     <= '0;
      vs_prev_q     <= 1'b0;
      hr_prev_q     <= 1'b0;
      byte_phase_q  <= 1'b0;
      line_abort_q  <= 1'b0;
      line_bytes_q  <= '0;
      line_cnt_q    <= '0;
      skip_cnt_q    <= '0;
      vsync_out_q   <= 1'b0;
      href_out_q    <= 1'b0;
      pix_data_q    <= '0;
      pix_valid_q   <= 1'b0;
      frame_count_q <= '0;
      line_err_q    <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      s1_vsync_q    <= s1_vsync_d;
      s1_href_q     <= s1_href_d;
      s1_data_q     <= s1_data_d;
      vs_prev_q     <= vs_prev_d;
      hr_prev_q     <= hr_prev_d;
      byte_phase_q  <= byte_phase_d;
      line_abort_q  <= line_abort_d;
      line_bytes_q  <= line_bytes_d;
      line_cnt_q    <= line_cnt_d;
      skip_cnt_q    <= skip_cnt_d;
      vsync_out_q   <= vsync_out_d;
      href_out_q    <= href_out_d;
      pix_data_q    <= pix_data_d;
      pix_valid_q   <= pix_valid_d;
      frame_count_q <= frame_count_d;
      line_err_q    <= line_err_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign vsync_out   = vsync_out_q;
  assign href_out    = href_out_q;
  assign pix_data    = pix_data_q;
  assign pix_valid   = pix_valid_q;
  assign frame_count = frame_count_q;
  assign line_err    = line_err_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_cam_byte_sync.sv
// Directed bench for cam_byte_sync using a reduced geometry (16x6) so whole
// frames fit in a short run. u_dut0 has no skip frames and a 3-bit frame
// counter; u_dut1 skips two frames.
module tb_cam_byte_sync;
  localparam int COLS = 16;
  localparam int ROWS = 6;
  localparam int LB   = 2 * COLS;

  logic        pclk = 1'b0;
  logic        reset;
  logic        cam_vsync, cam_href, luma_phase, en0, en1;
  logic [7:0]  cam_data;

  logic        vs0, hr0, pv0, le0, fe0;
  logic [7:0]  pd0;
  logic [2:0]  fc0;
  logic        vs1, hr1, pv1, le1, fe1;
  logic [7:0]  pd1;
  logic [15:0] fc1;

  cam_byte_sync #(.COLS(COLS), .ROWS(ROWS), .SKIP_FRAMES(0), .FCNT_W(3)) u_dut0 (
    .pclk(pclk), .reset(reset), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_data(cam_data), .enable(en0), .luma_phase(luma_phase),
    .vsync_out(vs0), .href_out(hr0), .pix_data(pd0), .pix_valid(pv0),
    .frame_count(fc0), .line_err(le0), .frame_err(fe0)
  );

  cam_byte_sync #(.COLS(COLS), .ROWS(ROWS), .SKIP_FRAMES(2), .FCNT_W(16)) u_dut1 (
    .pclk(pclk), .reset(reset), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_data(cam_data), .enable(en1), .luma_phase(luma_phase),
    .vsync_out(vs1), .href_out(hr1), .pix_data(pd1), .pix_valid(pv1),
    .frame_count(fc1), .line_err(le1), .frame_err(fe1)
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // expected u_dut0 strobes: sample cycle and byte
  int         q_c[$];
  logic [7:0] q_d[$];
  bit         q_on = 1'b1;

  int n_pix0 = 0, n_le0 = 0, n_fe0 = 0, n_pix1 = 0, n_le1 = 0, n_fe1 = 0;
  int le_cyc0 = -1, fe_cyc0 = -1, le_run = 0, fe_run = 0;

  initial forever begin
    @(negedge pclk);
    if (pv0) n_pix0++;
    if (pv1) n_pix1++;
    if (le1) n_le1++;
    if (fe1) n_fe1++;
    if (le0) begin
      n_le0++; le_cyc0 = cyc; le_run++;
    end else if (le_run != 0) begin
      check("line_err_width", le_run, 1); le_run = 0;
    end
    if (fe0) begin
      n_fe0++; fe_cyc0 = cyc; fe_run++;
    end else if (fe_run != 0) begin
      check("frame_err_width", fe_run, 1); fe_run = 0;
    end
    if (q_on) begin
      if (q_c.size() > 0 && q_c[0] == cyc) begin
        check("pix_valid", pv0, 1);
        check("pix_data", pd0, q_d[0]);
        void'(q_c.pop_front());
        void'(q_d.pop_front());
      end else begin
        check("pix_idle", pv0, 0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int fall_cyc, vs_cyc;

  task automatic tick(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic send_line(input int n, input bit exp);
    for (int i = 0; i < n; i++) begin
      cam_href = 1'b1;
      cam_data = 8'(i);
      if (exp && i < LB && (i % 2) == int'(luma_phase)) begin
        q_c.push_back(cyc + 2);
        q_d.push_back(8'(i));
      end
      tick(1);
    end
    cam_href = 1'b0;
    fall_cyc = cyc;
    tick(4);
  endtask

  task automatic send_vsync();
    cam_vsync = 1'b1;
    vs_cyc = cyc;
    tick(3);
    cam_vsync = 1'b0;
    tick(3);
  endtask

  task automatic send_frame(input int nl, input bit exp);
    for (int l = 0; l < nl; l++) send_line(LB, exp);
    send_vsync();
  endtask

  int p0, p1, le_b, fe_b;

  initial begin
    reset = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0; cam_data = '0;
    en0 = 1'b0; en1 = 1'b0; luma_phase = 1'b0;
    tick(3);
    check("rst_flags0", {vs0, hr0, pv0, le0, fe0}, 0);
    check("rst_pix_data0", pd0, 0);
    check("rst_fc0", fc0, 0);
    check("rst_fc1", fc1, 0);
    #1 reset = 1'b1;
    tick(2);

    // full good frame, YUYV
    en0 = 1'b1;
    tick(3);
    p0 = n_pix0;
    send_vsync();
    check("t1_fc_after_sync", fc0, 0);
    for (int l = 0; l < ROWS; l++) send_line(LB, 1'b1);
    send_vsync();
    check("t1_strobes", n_pix0 - p0, ROWS * COLS);
    check("t1_line_err", n_le0, 0);
    check("t1_frame_err", n_fe0, 0);
    check("t1_fc", fc0, 1);
    check("t1_queue", q_c.size(), 0);

    // UYVY line
    luma_phase = 1'b1;
    p0 = n_pix0;
    send_line(LB, 1'b1);
    check("t2_strobes", n_pix0 - p0, COLS);
    check("t2_queue", q_c.size(), 0);

    // short line and long line
    luma_phase = 1'b0;
    p0 = n_pix0;
    send_line(LB - 2, 1'b1);
    check("t3_short_strobes", n_pix0 - p0, COLS - 1);
    check("t3_short_le", n_le0, 1);
    check("t3_short_le_cyc", le_cyc0, fall_cyc + 2);
    p0 = n_pix0;
    send_line(LB + 2, 1'b1);
    check("t3_long_strobes", n_pix0 - p0, COLS);
    check("t3_long_le", n_le0, 2);
    check("t3_long_le_cyc", le_cyc0, fall_cyc + 2);

    // frame closes with ROWS-1 lines
    send_line(LB, 1'b1);
    send_line(LB, 1'b1);
    send_vsync();
    check("t4_short_fe", n_fe0, 1);
    check("t4_short_fe_cyc", fe_cyc0, vs_cyc + 2);
    check("t4_short_fc", fc0, 2);

    // frame with ROWS+1 lines; enable drops mid-frame
    for (int l = 0; l < 3; l++) send_line(LB, 1'b1);
    en0 = 1'b0;
    for (int l = 3; l < ROWS; l++) send_line(LB, 1'b1);
    p0 = n_pix0;
    send_line(LB, 1'b0);
    check("t4_extra_strobes", n_pix0 - p0, 0);
    check("t4_extra_le", n_le0, 2);
    send_vsync();
    check("t4_long_fe", n_fe0, 2);
    check("t4_long_fc", fc0, 3);
    check("t4_queue", q_c.size(), 0);

    // skip frames on u_dut1
    en1 = 1'b1;
    tick(3);
    p0 = n_pix0;
    p1 = n_pix1;
    send_vsync();
    send_frame(ROWS, 1'b0);
    send_frame(ROWS, 1'b0);
    check("t5_skipped_strobes", n_pix1 - p1, 0);
    check("t5_skipped_fc", fc1, 0);
    send_frame(ROWS, 1'b0);
    check("t5_f3_strobes", n_pix1 - p1, ROWS * COLS);
    check("t5_f3_fc", fc1, 1);
    for (int l = 0; l < 3; l++) send_line(LB, 1'b0);
    en1 = 1'b0;
    for (int l = 3; l < ROWS; l++) send_line(LB, 1'b0);
    send_vsync();
    check("t5_f4_strobes", n_pix1 - p1, 2 * ROWS * COLS);
    check("t5_fc", fc1, 2);
    check("t5_errs", n_le1 + n_fe1, 0);
    cam_vsync = 1'b1;
    tick(3);
    check("t5_idle_vsync_out1", vs1, 0);
    check("t5_idle_vsync_out0", vs0, 0);
    cam_vsync = 1'b0;
    tick(3);
    check("t5_dut0_idle_strobes", n_pix0 - p0, 0);

    // async reset mid-line, then vsync rise while href is high
    en0 = 1'b1;
    tick(3);
    send_vsync();
    q_on = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cam_href = 1'b1; cam_data = 8'(i); tick(1);
    end
    cam_data = 8'd10;
    check("t6_href_pre", hr0, 1);
    check("t6_fc_pre", fc0, 3);
    #2 reset = 1'b0;
    #1;
    check("t6_rst_flags", {vs0, hr0, pv0, le0, fe0}, 0);
    check("t6_rst_pix_data", pd0, 0);
    check("t6_rst_fc", fc0, 0);
    @(negedge pclk);
    #1 reset = 1'b1;
    p0 = n_pix0;
    le_b = n_le0;
    for (int i = 11; i < LB; i++) begin
      cam_data = 8'(i);
      if (i == 20) begin cam_vsync = 1'b1; vs_cyc = cyc; end
      if (i == 23) cam_vsync = 1'b0;
      tick(1);
    end
    cam_href = 1'b0;
    tick(4);
    check("t6_abort_le", n_le0 - le_b, 1);
    check("t6_abort_le_cyc", le_cyc0, vs_cyc + 2);
    check("t6_abort_strobes", n_pix0 - p0, 0);
    q_on = 1'b1;
    fe_b = n_fe0;
    send_frame(ROWS, 1'b1);
    check("t6_fc", fc0, 1);
    check("t6_fe", n_fe0 - fe_b, 0);
    check("t6_queue", q_c.size(), 0);

    // frame counter wrap (3 bits)
    le_b = n_le0;
    for (int f = 0; f < 8; f++) send_frame(ROWS, 1'b1);
    check("wrap_fc", fc0, 1);
    check("wrap_fe", n_fe0 - fe_b, 0);
    check("wrap_le", n_le0 - le_b, 0);
    check("wrap_queue", q_c.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
